// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and the latched-op record for the alu issue controller.
package alu_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_MUL = 4'b0001;
    localparam logic [3:0] OP_DIV = 4'b0010;
    localparam logic [3:0] OP_ROL = 4'b1000;
    localparam logic [3:0] OP_ROR = 4'b1001;
    localparam logic [3:0] OP_SLL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;
    localparam logic [3:0] OP_OR  = 4'b1100;
    localparam logic [3:0] OP_AND = 4'b1101;
    localparam logic [3:0] OP_SUB = 4'b1110;
    localparam logic [3:0] OP_ADD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // One accepted operation as held while the alu works on it.
    typedef struct packed {
        logic [3:0]  ctrl;
        logic [15:0] opa;
        logic [15:0] opb;
    } op_t;

    // Shift/rotate ops take only a 4-bit amount from the bottom operand.
    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the last winner loses a tie.
module rr_arb2
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic       grant,
    output logic       any_valid
);

    logic last_grant;

    // Pick the sole requester, or the one that did not win last time.
    always_comb begin
        any_valid = |valid;
        if (valid == 2'b11) grant = ~last_grant;
        else                grant = valid[1];
    end

    // Remember the winner only when the grant actually turns into an accept.
    always_ff @(posedge clk) begin
        if (rst)         last_grant <= 1'b1;
        else if (accept) last_grant <= grant;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares the EX alu between the pipeline and the debug port: arbitrate, hold one op
// on the alu for its latency, capture the result and hand it back over valid/ready.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [7:0]  req_ctrl,
    input  logic [31:0] req_opa,
    input  logic [31:0] req_opb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic [15:0] rsp_remainder,
    output logic        rsp_overflow,
    output logic        rsp_divzero,
    output logic        busy,
    output logic [3:0]  alu_ctrl,
    output logic [15:0] alu_opa,
    output logic [15:0] alu_opb,
    input  logic [15:0] alu_result,
    input  logic [15:0] alu_remainder,
    input  logic        alu_overflow
);

    state_e      state_q, state_d;
    op_t         op_q, req_op;
    logic [7:0]  cnt_q;
    logic        grant, any_valid, accept, div_zero;

    // Cycles-minus-one the alu inputs must be held before the outputs are trusted.
    function automatic logic [7:0] lat_m1(input logic [3:0] op);
        case (op)
            OP_MUL:  return 8'(MUL_CYCLES - 1);
            OP_DIV:  return 8'(DIV_CYCLES - 1);
            default: return 8'd0;
        endcase
    endfunction

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid     (req_valid),
        .accept    (accept),
        .grant     (grant),
        .any_valid (any_valid)
    );

    // Offer the slot to the granted requester only while idle; select its op fields.
    always_comb begin
        req_ready = 2'b00;
        if (state_q == ST_IDLE && any_valid) req_ready = grant ? 2'b10 : 2'b01;
        accept      = |(req_valid & req_ready);
        req_op.ctrl = grant ? req_ctrl[7:4]  : req_ctrl[3:0];
        req_op.opa  = grant ? req_opa[31:16] : req_opa[15:0];
        req_op.opb  = grant ? req_opb[31:16] : req_opb[15:0];
        div_zero    = (req_op.ctrl == OP_DIV) && (req_op.opb == 16'd0);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: divide-by-zero never reaches the alu and answers straight away.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = div_zero ? ST_DONE : ST_EXEC;
            ST_EXEC: if (cnt_q == 8'd0) state_d = ST_DONE;
            ST_DONE: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Op latches, latency counter and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q          <= '0;
            cnt_q         <= 8'd0;
            rsp_id        <= 1'b0;
            rsp_result    <= 16'd0;
            rsp_remainder <= 16'd0;
            rsp_overflow  <= 1'b0;
            rsp_divzero   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    op_q        <= req_op;
                    cnt_q       <= lat_m1(req_op.ctrl);
                    rsp_id      <= grant;
                    rsp_divzero <= div_zero;
                    if (div_zero) begin
                        rsp_result    <= 16'd0;
                        rsp_remainder <= 16'd0;
                        rsp_overflow  <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == 8'd0) begin
                        rsp_result    <= alu_result;
                        rsp_remainder <= alu_remainder;
                        rsp_overflow  <= alu_overflow;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Drive the alu only while executing; shift amounts are clamped to 4 bits.
    always_comb begin
        alu_ctrl = OP_NOP;
        alu_opa  = 16'd0;
        alu_opb  = 16'd0;
        if (state_q == ST_EXEC) begin
            alu_ctrl = op_q.ctrl;
            alu_opa  = op_q.opa;
            alu_opb  = is_shift(op_q.ctrl) ? {12'd0, op_q.opb[3:0]} : op_q.opb;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);

endmodule
